mem_dump_reader: RTL
====================

Name: mem_dump_reader

Overview:
- Halt-triggered readback engine for the unified 256x16 RAM.
- When the CPU asserts Halt (or software pulses a request), it walks an address window of RAM and streams {address, data} beats out over a valid/ready interface.
- Sits beside the datapath memory port. It is the reading end of the program-load path: the bench or a host consumes the stream instead of peeking memory hierarchically.

Parameters:
- AW, 8, RAM address width.
- DW, 16, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears while low.
- trigger  in  1  Halt level from the control unit; a dump starts on its rising edge.
- dump_req  in  1  single-cycle software start pulse; ORed with the trigger edge.
- start_addr  in  AW  first address to read; sampled at start.
- end_addr  in  AW  last address to read, inclusive; sampled at start.
- mem_req  out  1  request ownership of the RAM port.
- mem_gnt  in  1  RAM port granted.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  AW  read address, valid while mem_rd=1.
- mem_rdata  in  DW  read data, valid the cycle after mem_rd.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_addr  out  AW  address of the beat.
- out_data  out  DW  data of the beat.
- out_last  out  1  final beat of the dump.
- busy  out  1  high from start until DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset values: all outputs 0; state IDLE; trigger edge register 0.
- Start event = (trigger & ~trigger_d) | dump_req, evaluated in IDLE only. Start events in any other state are ignored.
- On start: latch start_addr into a 9-bit counter (cnt) and end_addr into lim; go to REQ.
- If start_addr > end_addr the window is empty:
  - Go straight to DONE with no memory reads and no data beats.
  - With the optional feature on, the checksum beat is still sent first (value 0000).
- IDLE: mem_req=0, busy=0.
- REQ: mem_req=1. Move to READ when mem_gnt=1.
- READ: mem_rd=1 and mem_addr=cnt[AW-1:0] for exactly one cycle; go to CAP.
- CAP:
  - Register out_addr=cnt and out_data=mem_rdata.
  - Set out_valid=1, with out_last=1 when cnt==lim and the checksum feature is off.
  - Go to SEND.
- SEND:
  - Hold out_addr, out_data and out_last stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: clear out_valid.
  - If cnt==lim: go to CSUM if the feature is on, otherwise DONE.
  - Otherwise: cnt+=1 and go to REQ.
- mem_req stays 1 from REQ through the end of the last SEND. If mem_gnt drops, the FSM stalls in REQ with no read issued.
- mem_gnt is only checked in REQ; a read already issued completes regardless.
- Wrap: cnt is 9 bits, so end_addr=FF ends correctly and never wraps to 00.
- Latency, with mem_gnt=1 and out_ready=1:
  - First out_valid is high 4 cycles after the trigger rising edge (IDLE→REQ→READ→CAP→SEND).
  - Each beat takes 4 cycles.
- DONE:
  - busy=0, done=1, mem_req=0.
  - Return to IDLE when trigger=0 and dump_req=0. done drops on that transition.
- Reset asserted mid-dump: abort immediately. out_valid=0 and mem_req=0 asynchronously; no partial beat is held.

Optional Feature:
- Macro: DUMP_CSUM_EN.
- When defined:
  - Keep a DW-bit running sum (mod 2^DW) of every out_data accepted.
  - After the last data beat, state CSUM emits one extra beat: out_addr={AW{1'b1}}, out_data=sum, out_last=1, with the same hold rules as SEND.
  - Go to DONE after the handshake. The sum clears on each start.
  - Data beats never assert out_last.
- When undefined: no CSUM state and no sum register; out_last is on the final data beat.

Test Plan:
- Preload RAM[20..22]=0008,0003,000D; start=20, end=22; raise trigger; out_ready=1 → three beats (20,0008),(21,0003),(22,000D); out_last on the third (on a fourth beat FF,0018 with DUMP_CSUM_EN); then done=1.
- Same window with out_ready toggled 1-0-0-1 every cycle → out_addr and out_data stable while stalled; same beat sequence; no beats dropped or duplicated.
- start=FE, end=FF → beats FE then FF; no read of address 00; done=1 afterwards.
- start=30, end=2F, dump_req pulse → no mem_rd and no data beats; done=1 within 2 cycles (one checksum beat 0000 with DUMP_CSUM_EN).
- mem_gnt held 0 for 5 cycles after the first beat → FSM waits in REQ, mem_rd stays 0, then resumes at the next address.
- Pull reset low during the second SEND → out_valid, mem_req and busy go 0 at once; after release, a new trigger restarts from start_addr.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Halt-triggered RAM readback: walks [start_addr..end_addr] and streams {addr,data} beats.
// Optional trailing checksum beat when DUMP_CSUM_EN is defined.
module mem_dump_reader #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          trigger,
   input  logic          dump_req,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] end_addr,
   output logic          mem_req,
   input  logic          mem_gnt,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_READ = 3'd2,
      S_CAP  = 3'd3,
      S_SEND = 3'd4,
      S_DONE = 3'd5
`ifdef DUMP_CSUM_EN
      , S_CSUM = 3'd6
`endif
   } state_t;

   state_t          state_q, state_d;
   logic            trig_q;
   logic [AW:0]     cnt_q, cnt_d;
   logic [AW:0]     lim_q, lim_d;
   logic [AW-1:0]   oaddr_q, oaddr_d;
   logic [DW-1:0]   odata_q, odata_d;
   logic            ovalid_q, ovalid_d;
   logic            olast_q, olast_d;
   logic            start;
   logic            at_end;
`ifdef DUMP_CSUM_EN
   logic [DW-1:0]   sum_q, sum_d;
`endif

   assign start  = (trigger & ~trig_q) | dump_req;
   assign at_end = (cnt_q == lim_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         trig_q   <= 1'b0;
         cnt_q    <= '0;
         lim_q    <= '0;
         oaddr_q  <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         olast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         trig_q   <= trigger;
         cnt_q    <= cnt_d;
         lim_q    <= lim_d;
         oaddr_q  <= oaddr_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         olast_q  <= olast_d;
      end
   end

`ifdef DUMP_CSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lim_d    = lim_q;
      oaddr_d  = oaddr_q;
      odata_d  = odata_q;
      ovalid_d = ovalid_q;
      olast_d  = olast_q;
`ifdef DUMP_CSUM_EN
      sum_d    = sum_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d = {1'b0, start_addr};
               lim_d = {1'b0, end_addr};
`ifdef DUMP_CSUM_EN
               sum_d = '0;
`endif
               if (start_addr > end_addr) begin
`ifdef DUMP_CSUM_EN
                  // Empty window still reports its (zero) checksum.
                  oaddr_d  = '1;
                  odata_d  = '0;
                  ovalid_d = 1'b1;
                  olast_d  = 1'b1;
                  state_d  = S_CSUM;
`else
                  state_d  = S_DONE;
`endif
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            oaddr_d  = cnt_q[AW-1:0];
            odata_d  = mem_rdata;
            ovalid_d = 1'b1;
`ifdef DUMP_CSUM_EN
            olast_d  = 1'b0;
`else
            olast_d  = at_end;
`endif
            state_d  = S_SEND;
         end
         S_SEND: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
`ifdef DUMP_CSUM_EN
               sum_d    = sum_q + odata_q;
`endif
               if (at_end) begin
`ifdef DUMP_CSUM_EN
                  oaddr_d  = '1;
                  odata_d  = sum_q + odata_q;
                  ovalid_d = 1'b1;
                  olast_d  = 1'b1;
                  state_d  = S_CSUM;
`else
                  state_d  = S_DONE;
`endif
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_REQ;
               end
            end
         end
`ifdef DUMP_CSUM_EN
         S_CSUM: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (!trigger && !dump_req) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Port ownership spans the whole per-beat loop, including the send wait.
   assign mem_req   = (state_q == S_REQ)  || (state_q == S_READ) ||
                      (state_q == S_CAP)  || (state_q == S_SEND);
   assign mem_rd    = (state_q == S_READ);
   assign mem_addr  = (state_q == S_READ) ? cnt_q[AW-1:0] : '0;
   assign out_valid = ovalid_q;
   assign out_addr  = oaddr_q;
   assign out_data  = odata_q;
   assign out_last  = olast_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);

endmodule
